// File: rtl/sipo_pkg.sv
// Shared constants, output FSM state type and count-width helper for the SIPO deserializer.
// SIPO_PARITY_EN adds one even-parity bit to every frame.
package sipo_pkg;

  localparam bit SIPO_LSB_FIRST = 1'b0;
  localparam bit SIPO_MSB_FIRST = 1'b1;

`ifdef SIPO_PARITY_EN
  localparam int unsigned SIPO_PAR_BITS = 1;
`else
  localparam int unsigned SIPO_PAR_BITS = 0;
`endif

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } out_state_e;

  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; frame_o is the word including the bit accepted this cycle.
module sipo_shift_core #(
  parameter int unsigned FRAME     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CW        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             serial_i,
  input  logic             clear_i,
  output logic [FRAME-1:0] frame_o,
  output logic             word_done_o,
  output logic [CW-1:0]    bit_cnt_o
);

  logic [FRAME-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  assign accept = in_valid_i & ~clear_i;

  always_comb begin
    if (MSB_FIRST) shift_d = {shift_q[FRAME-2:0], serial_i};
    else           shift_d = {serial_i, shift_q[FRAME-1:1]};
  end

  assign word_done_o = accept && (cnt_q == CW'(FRAME - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)          cnt_d = '0;
    else if (word_done_o) cnt_d = '0;
    else if (accept)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clear_i)     shift_q <= '0;
      else if (accept) shift_q <= shift_d;
    end
  end

  assign frame_o   = shift_d;
  assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with one-entry valid/ready holding register and sticky overrun.
// SIPO_PARITY_EN: frame carries a trailing even-parity bit, reported on parity_err.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  bit          MSB_FIRST = SIPO_MSB_FIRST,
  localparam int unsigned FRAME     = WIDTH + SIPO_PAR_BITS,
  localparam int unsigned CW        = cnt_width(FRAME)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             serial_in,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  logic [FRAME-1:0] frame;
  logic             done;
  logic [WIDTH-1:0] word;
  out_state_e       state_q, state_d;
  logic             load;
  logic [WIDTH-1:0] data_q;
  logic             ovr_q, ovr_d;

  sipo_shift_core #(
    .FRAME     (FRAME),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .serial_i    (serial_in),
    .clear_i     (clear),
    .frame_o     (frame),
    .word_done_o (done),
    .bit_cnt_o   (bit_cnt)
  );

  // Parity, when present, sits at the end of the frame opposite the data's first bit.
  assign word = MSB_FIRST ? frame[FRAME-1 -: WIDTH] : frame[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      ST_EMPTY: begin
        if (done) begin
          state_d = ST_FULL;
          load    = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (done) load = 1'b1;
          else      state_d = ST_EMPTY;
        end else if (done) begin
          ovr_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
      if (load) data_q <= word;
    end
  end

`ifdef SIPO_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst)       perr_q <= 1'b0;
    else if (load) perr_q <= ^frame;
  end

  assign parity_err = perr_q;
`endif

  assign out_data  = data_q;
  assign out_valid = (state_q == ST_FULL);
  assign overrun   = ovr_q;

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserializer with a per-bit valid qualifier, selectable bit order, and a one-entry output holding register behind a valid/ready handshake.
- Collects WIDTH serial bits into a word and presents it to a downstream consumer.
- Flags words lost to backpressure.
- Successor to the fixed 4-bit shifter; sits between a serial link front-end and word-wide datapath logic.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 1, 1: first accepted bit lands in out_data[WIDTH-1]; 0: first accepted bit lands in out_data[0].

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  serial_in carries a valid bit this cycle.
serial_in  input  1  serial data bit.
clear  input  1  synchronous frame abort; discards partial word.
out_data  output  WIDTH  assembled word; stable while out_valid=1.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid&out_ready.
overrun  output  1  sticky: a completed word was dropped.
bit_cnt  output  $clog2(WIDTH)  bits collected in the current partial word (debug/status).

Behaviour:
- Reset (rst=1 at a clk edge) overrides all other inputs:
  - shift register, bit_cnt, out_data, out_valid and overrun all become 0.
  - A partial word in progress is discarded.
- Bit accept: a bit is accepted on any cycle with in_valid=1 and clear=0.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB (first bit ends at [0]).
  - bit_cnt increments; it wraps to 0 on the WIDTH-th bit.
- Word complete: the cycle that accepts bit WIDTH-1 (bit_cnt==WIDTH-1, in_valid=1).
  - The assembled word, including that bit, goes to the holding register.
  - out_valid=1 on the following cycle (latency 1 clk after the last bit).
  - A new frame starts immediately; back-to-back frames need no idle cycle.
- Output FSM, two states:
  - EMPTY (out_valid=0): complete -> FULL, word loaded.
  - FULL (out_valid=1), by inputs in the same cycle:
    - out_ready=1, no complete -> EMPTY.
    - out_ready=1 and complete -> stay FULL, new word loaded (no bubble).
    - out_ready=0 and complete -> stay FULL, held word unchanged, new word dropped, overrun<=1.
    - out_ready=0, no complete -> hold.
- overrun is cleared only by rst; clear does not touch it.
- clear=1:
  - shift register and bit_cnt <=0; in_valid ignored that cycle.
  - The holding register, out_valid and the handshake are unaffected. A held word is still deliverable.
- out_ready while EMPTY: ignored.
- out_data retains its last value when EMPTY. It changes only on a load.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 accepted bits; the final bit is even parity over the WIDTH data bits.
  - bit_cnt widens to $clog2(WIDTH+1).
  - Extra output port parity_err (1 bit) loads alongside out_data: 1 when XOR(data bits, parity bit) != 0.
  - The word is delivered regardless of parity_err.
  - parity_err resets to 0 and is valid only while out_valid=1.
- Undefined:
  - Frame is exactly WIDTH bits.
  - No parity_err port and no parity logic.

Decomposition:
- Package sipo_pkg:
  - Bit-order constants (SIPO_LSB_FIRST=0, SIPO_MSB_FIRST=1).
  - Output FSM state enum (ST_EMPTY, ST_FULL).
  - A count-width function returning $clog2 of the frame length.
- One sub-module, sipo_shift_core: shift register plus bit counter, parametrised by WIDTH/MSB_FIRST.
  - Outputs the assembled word and a one-cycle word_done pulse.
- The top holds the FSM, holding register, overrun and parity check.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 -> out_data=8'hA5, out_valid high exactly 1 cycle, 1 clk after the 8th bit.
2. WIDTH=8, MSB_FIRST=0: same bit stream -> out_data=8'hA5 reversed = 8'hA5 (palindrome check fails), so use stream 1,1,0,0,0,0,0,0 -> 8'h03; MSB_FIRST=1 with the same stream -> 8'hC0.
3. in_valid gapped (1 every 3 cycles) for 8 bits -> bit_cnt steps 0..7, single word 8'hA5; no output between bits.
4. Backpressure: out_ready=0, send two full frames 8'h11 then 8'h22 -> out_data stays 8'h11, overrun=1. Then out_ready=1 -> out_valid drops; overrun stays 1 until rst.
5. Abort: 5 bits in, clear=1, then 8 bits of 8'h3C -> out_data=8'h3C, not corrupted by stale bits. clear while FULL -> held word still delivered.
6. rst asserted mid-frame (bit_cnt=4) and while FULL -> next cycle all outputs 0; the following full frame 8'hF0 is delivered correctly. With SIPO_PARITY_EN: 8'hA5 plus parity bit 1 -> parity_err=1; parity bit 0 -> parity_err=0.
